// File: rtl/vram_writer_pkg.sv
// Shared constants for the video RAM write path: MCU command codes and word width.
package vram_writer_pkg;

    localparam logic [7:0] CMD_SET_ADDRESS = 8'h01;
    localparam int         WORD_W          = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and extra-bit pointers for full/empty.
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_idx == rd_idx);
    // Same slot, different lap bit: writer is a full lap ahead.
    assign full    = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
    assign dout    = mem[rd_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (do_push) wr_idx <= wr_idx + 1'b1;
            if (do_pop)  rd_idx <= rd_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Packs MCU pixel bytes into 16-bit words at an auto-incrementing word address,
// buffers them and drains them to the video RAM arbiter over req/ack.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  cmdclk,
    input  logic                  dataclk,
    input  logic [7:0]            cmd_code,
    input  logic [7:0]            data_in,
    input  logic [31:0]           address_in,
    input  logic                  ovf_clear,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  pending_byte,
    output logic                  overflow
);

    localparam int ENTRY_W = ADDR_WIDTH + WORD_W;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [7:0]            low_byte;
    logic                  push_vld;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  set_addr;
    logic                  load;
    logic                  unused_addr_hi;

    assign set_addr       = cmdclk && (cmd_code == CMD_SET_ADDRESS);
    assign unused_addr_hi = ^address_in[31:ADDR_WIDTH];

    // Byte packing and write pointer. A byte arriving with SET_ADDRESS always
    // starts a fresh word at the new address, so the later assignments win.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            low_byte     <= '0;
            pending_byte <= 1'b0;
            push_vld     <= 1'b0;
            push_entry   <= '0;
        end else begin
            push_vld <= 1'b0;
            if (set_addr) begin
                wr_ptr       <= address_in[ADDR_WIDTH-1:0];
                pending_byte <= 1'b0;
            end
            if (dataclk) begin
                if (set_addr || !pending_byte) begin
                    low_byte     <= data_in;
                    pending_byte <= 1'b1;
                end else begin
                    push_vld     <= 1'b1;
                    push_entry   <= {wr_ptr, data_in, low_byte};
                    wr_ptr       <= wr_ptr + 1'b1;
                    pending_byte <= 1'b0;
                end
            end
        end
    end

    // A word that finds the FIFO full is lost; the pointer has already moved on.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_vld && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (rst),
        .push  (push_vld),
        .din   (push_entry),
        .pop   (load),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register refills in the ack cycle so writes can stream back-to-back.
    assign load = !fifo_empty && (!mem_req || mem_ack);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load) begin
            mem_req   <= 1'b1;
            mem_addr  <= head[ENTRY_W-1:WORD_W];
            mem_wdata <= head[WORD_W-1:0];
        end else if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
        end
    end

    assign busy = mem_req || !fifo_empty;

endmodule

// File: tb/tb_vram_writer.sv
// Randomized scoreboard bench for vram_writer: a byte-stream reference model
// predicts every (address, word) write; a monitor checks each accepted write.
module tb_vram_writer;
    import vram_writer_pkg::*;

    localparam int AW    = 19;
    localparam int DEPTH = 8;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic          cmdclk = 1'b0;
    logic          dataclk = 1'b0;
    logic [7:0]    cmd_code = 8'h00;
    logic [7:0]    data_in = 8'h00;
    logic [31:0]   address_in = 32'h0;
    logic          ovf_clear = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          pending_byte;
    logic          overflow;

    vram_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk(sysclk), .rst(rst), .cmdclk(cmdclk), .dataclk(dataclk),
        .cmd_code(cmd_code), .data_in(data_in), .address_in(address_in),
        .ovf_clear(ovf_clear), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy),
        .pending_byte(pending_byte), .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            ack_mode = 0;   // 0: hold low, 1: hold high, 2: random
    logic [AW-1:0] m_ptr = '0;
    logic          m_pend = 1'b0;
    logic [7:0]    m_low = 8'h00;
    logic          exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Reference: byte pairs form little-endian words at consecutive addresses;
    // with the drain blocked, only FIFO_DEPTH+1 words can be outstanding.
    task automatic model_byte(input logic [7:0] b);
        wr_t e;
        if (!m_pend) begin
            m_low  = b;
            m_pend = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH + 1) begin
                exp_ovf = 1'b1;
            end else begin
                e.addr = m_ptr;
                e.data = {b, m_low};
                exp_q.push_back(e);
            end
            m_ptr  = m_ptr + 1'b1;
            m_pend = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        dataclk = 1'b1;
        data_in = b;
        step();
        dataclk = 1'b0;
        model_byte(b);
    endtask

    task automatic set_addr(input logic [31:0] a);
        cmdclk     = 1'b1;
        cmd_code   = CMD_SET_ADDRESS;
        address_in = a;
        step();
        cmdclk = 1'b0;
        m_ptr  = a[AW-1:0];
        m_pend = 1'b0;
    endtask

    task automatic cmd_and_byte(input logic [31:0] a, input logic [7:0] b);
        cmdclk     = 1'b1;
        cmd_code   = CMD_SET_ADDRESS;
        address_in = a;
        dataclk    = 1'b1;
        data_in    = b;
        step();
        cmdclk  = 1'b0;
        dataclk = 1'b0;
        m_ptr   = a[AW-1:0];
        m_pend  = 1'b0;
        model_byte(b);
    endtask

    task automatic other_cmd(input logic [7:0] code, input logic [31:0] a);
        cmdclk     = 1'b1;
        cmd_code   = (code == CMD_SET_ADDRESS) ? (code ^ 8'h80) : code;
        address_in = a;
        step();
        cmdclk = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || busy) && i < max) begin
            step();
            i++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic wait_req(input int max);
        int i = 0;
        while (!mem_req && i < max) begin
            step();
            i++;
        end
        chk("req_timeout", mem_req, 1);
    endtask

    task automatic wait_room(input int max);
        int i = 0;
        while (exp_q.size() >= 6 && i < max) begin
            step();
            i++;
        end
        if (exp_q.size() >= 6) begin
            n_cmp++;
            n_err++;
            $display("FAIL room_timeout: outstanding %0d required below 6", exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pending"}, pending_byte, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr   = '0;
        m_pend  = 1'b0;
        m_low   = 8'h00;
        exp_ovf = 1'b0;
    endtask

    // Ack driver: changes settle well before the falling edge.
    initial begin
        forever begin
            @(posedge sysclk);
            #2;
            case (ack_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'b1;
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a write is accepted at the rising edge following a falling
    // edge where req and ack are both high.
    initial begin
        wr_t e;
        forever begin
            @(negedge sysclk);
            if (!rst && mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] hold_addr;
        logic [15:0]   hold_data;

        // Power-on reset
        #1;
        chk_reset_outputs("por");
        step();
        step();
        rst = 1'b0;
        model_reset();

        // Basic write pair with latency check
        ack_mode = 1;
        step();
        set_addr(32'h0000_0100);
        send_byte(8'h34);
        chk("basic_pending_lo", pending_byte, 1);
        send_byte(8'h12);
        chk("basic_pending_hi", pending_byte, 0);
        chk("lat_edge0", mem_req, 0);
        step();
        chk("lat_edge1", mem_req, 0);
        step();
        chk("lat_edge2", mem_req, 1);
        chk("lat_addr", mem_addr, 32'h100);
        send_byte(8'h78);
        send_byte(8'h56);
        wait_drain(50);

        // Address wrap
        set_addr(32'h0007_FFFF);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_drain(50);

        // Partial byte discarded by SET_ADDRESS; upper address bits ignored
        send_byte(8'h99);
        chk("discard_pending_set", pending_byte, 1);
        set_addr(32'hFFF8_0200);
        chk("discard_pending_clr", pending_byte, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_drain(50);

        // Command and byte in the same cycle
        send_byte(8'h55);
        cmd_and_byte(32'h300, 8'h66);
        chk("simul_pending", pending_byte, 1);
        send_byte(8'h77);
        wait_drain(50);

        // Stall: outputs hold, foreign commands ignored, one ack pops one word
        ack_mode = 0;
        step();
        set_addr(32'h400);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_req(20);
        hold_addr = mem_addr;
        hold_data = mem_wdata;
        chk("stall_first_addr", hold_addr, 32'h400);
        for (int i = 0; i < 5; i++) begin
            other_cmd(8'($urandom), $urandom);
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, hold_addr);
            chk("stall_data", mem_wdata, hold_data);
        end
        ack_mode = 1;
        step();
        ack_mode = 0;
        step();
        chk("stall_one_pop", exp_q.size(), 1);
        chk("stall_next_req", mem_req, 1);
        chk("stall_next_addr", mem_addr, 32'h401);
        send_byte(8'h05);
        send_byte(8'h06);
        ack_mode = 1;
        wait_drain(50);

        // Overflow: ten words with the drain blocked
        ack_mode = 0;
        step();
        set_addr(32'h0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom));
        step();
        step();
        chk("ovf_set", overflow, exp_ovf);
        chk("ovf_busy", busy, 1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        exp_ovf   = 1'b0;
        chk("ovf_cleared", overflow, 0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        ovf_clear = 1'b1;   // coincides with the dropped push
        step();
        ovf_clear = 1'b0;
        chk("ovf_set_wins", overflow, exp_ovf);
        ack_mode = 1;
        wait_drain(100);
        chk("ovf_sticky", overflow, 1);
        send_byte(8'hD1);
        send_byte(8'hD2);
        wait_drain(50);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        exp_ovf   = 1'b0;

        // Randomized traffic with random ack
        ack_mode = 2;
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                if (m_pend) wait_room(200);
                send_byte(8'($urandom));
            end else if (r < 65) begin
                set_addr($urandom);
            end else if (r < 70) begin
                other_cmd(8'($urandom), $urandom);
            end else if (r < 74) begin
                cmd_and_byte($urandom, 8'($urandom));
            end else begin
                step();
            end
        end
        ack_mode = 1;
        wait_drain(200);
        chk("rand_overflow", overflow, exp_ovf);

        // Reset mid-stream with a request outstanding
        ack_mode = 0;
        step();
        set_addr(32'h123);
        send_byte(8'hE1);
        send_byte(8'hE2);
        wait_req(20);
        send_byte(8'hE3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        step();
        step();
        rst = 1'b0;
        ack_mode = 1;
        for (int i = 0; i < 6; i++) step();
        chk("midrst_idle", mem_req, 0);
        send_byte(8'hF0);
        send_byte(8'h0F);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
